cpu_sequencer: RTL and testbench

//  Parametrised successor to the CPU control sequencer. Steps each instruction through fetch/execute

---
 rtl/cpu_sequencer_pkg.sv | 70 +++++++
 rtl/cpu_sequencer_if.sv | 30 +++
 rtl/cpu_seq_decode.sv | 59 +++++
 rtl/cpu_sequencer.sv | 94 +++++++++
 tb/tb_cpu_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Purpose: shared opcode encodings, micro-state codes and instruction classes for the sequencer.
// Latency: n/a (types, constants and a pure classification function).
// Backpressure: n/a.
package cpu_sequencer_pkg;

    // Micro-state codes driven onto the control-word decoder select.
    typedef enum logic [3:0] {
        STATE_FETCH_PC   = 4'd0,
        STATE_FETCH_INST = 4'd1,
        STATE_HALT       = 4'd2,
        STATE_OUT_A      = 4'd3,
        STATE_NEXT       = 4'd4,
        STATE_JUMP       = 4'd5,
        STATE_LDI        = 4'd6,
        STATE_LOAD_ADDR  = 4'd7,
        STATE_RAM_A      = 4'd8,
        STATE_STORE_A    = 4'd9,
        STATE_RAM_B      = 4'd10,
        STATE_ALU_OP     = 4'd11
    } state_e;

    // Instruction classes: opcodes that share a micro-sequence collapse to one class.
    typedef enum logic [3:0] {
        CLASS_NOP     = 4'd0,
        CLASS_HLT     = 4'd1,
        CLASS_OUT     = 4'd2,
        CLASS_JMP     = 4'd3,
        CLASS_JEZ     = 4'd4,
        CLASS_JNZ     = 4'd5,
        CLASS_LDI     = 4'd6,
        CLASS_LDA     = 4'd7,
        CLASS_STA     = 4'd8,
        CLASS_ALU     = 4'd9,
        CLASS_ILLEGAL = 4'd10
    } class_e;

    // Opcode encodings. LDI carries a 3-bit register field in its low bits.
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_HLT = 8'h01;
    localparam logic [7:0] OP_OUT = 8'h02;
    localparam logic [7:0] OP_JMP = 8'h10;
    localparam logic [7:0] OP_JEZ = 8'h11;
    localparam logic [7:0] OP_JNZ = 8'h12;
    localparam logic [7:0] OP_LDI = 8'h20;
    localparam logic [7:0] OP_LDA = 8'h30;
    localparam logic [7:0] OP_STA = 8'h31;
    localparam logic [7:0] OP_ADD = 8'h40;
    localparam logic [7:0] OP_SUB = 8'h41;

    // Map an opcode onto its micro-sequence class; anything unlisted is illegal.
    function automatic class_e classify(input logic [7:0] op);
        class_e c;
        casez (op)
            OP_NOP:       c = CLASS_NOP;
            OP_HLT:       c = CLASS_HLT;
            OP_OUT:       c = CLASS_OUT;
            OP_JMP:       c = CLASS_JMP;
            OP_JEZ:       c = CLASS_JEZ;
            OP_JNZ:       c = CLASS_JNZ;
            8'b0010_0???: c = CLASS_LDI;
            OP_LDA:       c = CLASS_LDA;
            OP_STA:       c = CLASS_STA;
            OP_ADD,
            OP_SUB:       c = CLASS_ALU;
            default:      c = CLASS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Purpose: groups the instruction/flag/control inputs and the sequencer status outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall is carried as a plain level signal.
interface cpu_sequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int STATE_W  = 4,
    parameter int CYCLE_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                flag_zero;
    logic                stall;
    logic                resume;
    logic [STATE_W-1:0]  state;
    logic [CYCLE_W-1:0]  cycle;
    logic                instr_done;
    logic                halted;
    logic                illegal_op;

    // Side that owns the instruction register and memory/ALU status.
    modport master (
        output opcode, flag_zero, stall, resume,
        input  state, cycle, instr_done, halted, illegal_op
    );

    // The sequencer itself.
    modport slave (
        input  opcode, flag_zero, stall, resume,
        output state, cycle, instr_done, halted, illegal_op
    );
endinterface

// File: rtl/cpu_seq_decode.sv
// Purpose: combinational (class, cycle, flag_zero) -> next micro-state and end-of-instruction marker.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides whether the result is registered.
module cpu_seq_decode
    import cpu_sequencer_pkg::*;
#(
    parameter int CYCLE_W   = 4,
    parameter int MAX_CYCLE = 6
) (
    input  class_e             cls,
    input  logic [CYCLE_W-1:0] cycle,
    input  logic               flag_zero,
    output state_e             state,
    output logic               is_next
);

    // Decode table; any out-of-range cycle (upset) falls back to NEXT so the counter recovers.
    always_comb begin
        state = STATE_NEXT;
        if (cycle <= CYCLE_W'(MAX_CYCLE)) begin
            case (cycle)
                CYCLE_W'(0): state = STATE_FETCH_PC;
                CYCLE_W'(1): state = STATE_FETCH_INST;
                CYCLE_W'(2): begin
                    case (cls)
                        CLASS_HLT:     state = STATE_HALT;
                        CLASS_OUT:     state = STATE_OUT_A;
                        CLASS_ILLEGAL: state = STATE_NEXT;
                        default:       state = STATE_FETCH_PC;
                    endcase
                end
                CYCLE_W'(3): begin
                    case (cls)
                        CLASS_JMP:     state = STATE_JUMP;
                        CLASS_JEZ:     state = flag_zero ? STATE_JUMP : STATE_NEXT;
                        CLASS_JNZ:     state = flag_zero ? STATE_NEXT : STATE_JUMP;
                        CLASS_LDI:     state = STATE_LDI;
                        CLASS_LDA,
                        CLASS_STA,
                        CLASS_ALU:     state = STATE_LOAD_ADDR;
                        default:       state = STATE_NEXT;
                    endcase
                end
                CYCLE_W'(4): begin
                    case (cls)
                        CLASS_LDA:     state = STATE_RAM_A;
                        CLASS_STA:     state = STATE_STORE_A;
                        CLASS_ALU:     state = STATE_RAM_B;
                        default:       state = STATE_NEXT;
                    endcase
                end
                CYCLE_W'(5): state = (cls == CLASS_ALU) ? STATE_ALU_OP : STATE_NEXT;
                default:     state = STATE_NEXT;
            endcase
        end
        is_next = (state == STATE_NEXT);
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Purpose: steps each instruction through fetch/execute micro-states with halt, stall and trap handling.
// Latency: one micro-state per enabled clock; all outputs registered.
// Backpressure: stall=1 freezes every register and forces instr_done low.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int OPCODE_W  = 8,
    parameter int STATE_W   = 4,
    parameter int CYCLE_W   = 4,
    parameter int MAX_CYCLE = 6
) (
    input logic           clk,
    input logic           reset,
    cpu_sequencer_if.slave bus
);

    localparam logic [CYCLE_W-1:0] CYC_LATCH = CYCLE_W'(2);
    localparam logic [CYCLE_W-1:0] CYC_HALT  = CYCLE_W'(3);

    class_e              cls;
    state_e              dec_state;
    logic                dec_next;
    logic                at_latch;

    state_e              state_q;
    logic [CYCLE_W-1:0]  cycle_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic                instr_done_q;
    logic                halted_q;
    logic                illegal_q;

    assign at_latch = (cycle_q == CYC_LATCH);

    // On the latch cycle the class comes from the live opcode; afterwards from the held copy.
    always_comb begin
        cls = classify(at_latch ? 8'(bus.opcode) : 8'(opcode_q));
    end

    cpu_seq_decode #(
        .CYCLE_W   (CYCLE_W),
        .MAX_CYCLE (MAX_CYCLE)
    ) u_decode (
        .cls       (cls),
        .cycle     (cycle_q),
        .flag_zero (bus.flag_zero),
        .state     (dec_state),
        .is_next   (dec_next)
    );

    // Sequencer state: priority is reset, then stall, then halt/resume, then normal stepping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= STATE_FETCH_PC;
            cycle_q      <= '0;
            opcode_q     <= '0;
            instr_done_q <= 1'b0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else if (bus.stall) begin
            instr_done_q <= 1'b0;
        end else if (halted_q) begin
            if (bus.resume) begin
                state_q      <= STATE_NEXT;
                cycle_q      <= '0;
                instr_done_q <= 1'b1;
                halted_q     <= 1'b0;
            end else begin
                state_q      <= STATE_HALT;
                cycle_q      <= CYC_HALT;
                instr_done_q <= 1'b0;
            end
        end else begin
            state_q      <= dec_state;
            cycle_q      <= dec_next ? '0 : cycle_q + CYCLE_W'(1);
            instr_done_q <= dec_next;
            if (at_latch) begin
                opcode_q <= bus.opcode;
                if (cls == CLASS_ILLEGAL) begin
                    illegal_q <= 1'b1;
                end
            end
            if (dec_state == STATE_HALT) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.state      = STATE_W'(state_q);
    assign bus.cycle      = cycle_q;
    assign bus.instr_done = instr_done_q;
    assign bus.halted     = halted_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Purpose: randomized + directed stimulus against an instruction-level reference model with a scoreboard.
// Latency: expected outputs are queued per edge and compared on the following falling edge.
// Backpressure: stall and resume are driven randomly alongside the directed sequences.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] cyc;
        logic       done;
        logic       halted;
        logic       ill;
    } exp_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state: position inside the current instruction's micro-sequence.
    int     m_step;
    class_e m_cls;
    state_e m_state;
    logic   m_done;
    logic   m_halted;
    logic   m_ill;

    cpu_sequencer_if #(.OPCODE_W(8), .STATE_W(4), .CYCLE_W(4)) bus ();

    cpu_sequencer #(
        .OPCODE_W  (8),
        .STATE_W   (4),
        .CYCLE_W   (4),
        .MAX_CYCLE (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Instruction set as listed in the ISA table.
    function automatic class_e ref_class(input logic [7:0] op);
        logic [7:0] ldi;
        ldi = OP_LDI;
        if (op == OP_NOP) return CLASS_NOP;
        if (op == OP_HLT) return CLASS_HLT;
        if (op == OP_OUT) return CLASS_OUT;
        if (op == OP_JMP) return CLASS_JMP;
        if (op == OP_JEZ) return CLASS_JEZ;
        if (op == OP_JNZ) return CLASS_JNZ;
        if (op[7:3] == ldi[7:3]) return CLASS_LDI;
        if (op == OP_LDA) return CLASS_LDA;
        if (op == OP_STA) return CLASS_STA;
        if (op == OP_ADD || op == OP_SUB) return CLASS_ALU;
        return CLASS_ILLEGAL;
    endfunction

    // Full micro-sequence of each instruction kind, indexed by position within it.
    function automatic state_e ref_seq(input class_e c, input logic fz, input int idx);
        state_e s[7];
        s[0] = STATE_FETCH_PC;
        s[1] = STATE_FETCH_INST;
        s[2] = STATE_FETCH_PC;
        for (int i = 3; i < 7; i++) s[i] = STATE_NEXT;
        case (c)
            CLASS_HLT:     s[2] = STATE_HALT;
            CLASS_OUT:     s[2] = STATE_OUT_A;
            CLASS_ILLEGAL: s[2] = STATE_NEXT;
            CLASS_JMP:     s[3] = STATE_JUMP;
            CLASS_JEZ:     s[3] = fz ? STATE_JUMP : STATE_NEXT;
            CLASS_JNZ:     s[3] = fz ? STATE_NEXT : STATE_JUMP;
            CLASS_LDI:     s[3] = STATE_LDI;
            CLASS_LDA:     begin s[3] = STATE_LOAD_ADDR; s[4] = STATE_RAM_A;   end
            CLASS_STA:     begin s[3] = STATE_LOAD_ADDR; s[4] = STATE_STORE_A; end
            CLASS_ALU:     begin s[3] = STATE_LOAD_ADDR; s[4] = STATE_RAM_B; s[5] = STATE_ALU_OP; end
            default:       ;
        endcase
        return s[idx];
    endfunction

    // Drive one clock's worth of inputs and queue the outputs expected after that edge.
    task automatic step(input logic rst, input logic st, input logic res,
                        input logic [7:0] op, input logic fz);
        exp_t   e;
        class_e c;
        @(negedge clk);
        #1;
        reset         = rst;
        bus.stall     = st;
        bus.resume    = res;
        bus.opcode    = op;
        bus.flag_zero = fz;
        if (rst) begin
            m_step = 0; m_cls = CLASS_NOP; m_state = STATE_FETCH_PC;
            m_done = 1'b0; m_halted = 1'b0; m_ill = 1'b0;
        end else if (st) begin
            m_done = 1'b0;
        end else if (m_halted) begin
            if (res) begin
                m_state = STATE_NEXT; m_done = 1'b1; m_halted = 1'b0; m_step = 0;
            end else begin
                m_done = 1'b0;
            end
        end else begin
            c = (m_step == 2) ? ref_class(op) : m_cls;
            if (m_step == 2) begin
                m_cls = c;
                if (c == CLASS_ILLEGAL) m_ill = 1'b1;
            end
            m_state = ref_seq(c, fz, m_step);
            m_done  = (m_state == STATE_NEXT);
            if (m_state == STATE_HALT) begin
                m_halted = 1'b1;
                m_step   = 3;
            end else if (m_state == STATE_NEXT) begin
                m_step = 0;
            end else begin
                m_step = m_step + 1;
            end
        end
        e.st     = m_state;
        e.cyc    = 4'(m_step);
        e.done   = m_done;
        e.halted = m_halted;
        e.ill    = m_ill;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every edge produces one observable output word.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e          = exp_q.pop_front();
                got.st     = bus.state;
                got.cyc    = bus.cycle;
                got.done   = bus.instr_done;
                got.halted = bus.halted;
                got.ill    = bus.illegal_op;
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL seq_out t=%0t got st=%0d cyc=%0d done=%b halt=%b ill=%b want st=%0d cyc=%0d done=%b halt=%b ill=%b",
                             $time, got.st, got.cyc, got.done, got.halted, got.ill,
                             e.st, e.cyc, e.done, e.halted, e.ill);
                end
            end
        end
    end

    logic [7:0] ops [12] = '{OP_NOP, OP_HLT, OP_OUT, OP_JMP, OP_JEZ, OP_JNZ,
                             8'h20, 8'h25, OP_LDA, OP_STA, OP_ADD, OP_SUB};

    // Directed scenarios first, then a long randomized run.
    initial begin
        reset = 1'b1; bus.stall = 1'b0; bus.resume = 1'b0;
        bus.opcode = 8'h00; bus.flag_zero = 1'b0;

        step(1, 0, 0, OP_LDA, 0);
        repeat (6) step(0, 0, 0, OP_LDA, 0);
        repeat (8) step(0, 0, 0, OP_ADD, 0);
        repeat (4) step(0, 0, 0, OP_JEZ, 1);
        repeat (4) step(0, 0, 0, OP_JEZ, 0);
        repeat (4) step(0, 0, 0, OP_JNZ, 0);
        repeat (4) step(0, 0, 0, OP_LDA, 0);
        repeat (3) step(0, 1, 0, OP_LDA, 0);
        repeat (3) step(0, 0, 0, OP_LDA, 0);
        repeat (3) step(0, 0, 0, OP_HLT, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 8'($urandom), 1'($urandom));
        step(0, 1, 1, OP_NOP, 0);
        step(0, 0, 1, OP_NOP, 0);
        repeat (2) step(0, 0, 0, OP_NOP, 0);
        repeat (3) step(0, 0, 0, 8'hFF, 0);
        repeat (4) step(0, 0, 0, OP_ADD, 0);
        step(1, 0, 0, OP_ADD, 0);
        repeat (2) step(0, 0, 0, OP_ADD, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] op;
            logic       r, s, res;
            op  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : ops[$urandom_range(0, 11)];
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 99) < 12);
            res = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            step(r, s, res, op, 1'($urandom));
        end

        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected outputs left unchecked, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
